// File: rtl/mpu_clock_gen_if.sv
// Control, breakpoint and pulse-output bundle between the front panel logic
// and the 6502 phase-2 clock generator.
interface mpu_clock_gen_if #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int ADDR_WIDTH  = 16
);

  logic [1:0]             mode;
  logic [DIV_WIDTH-1:0]   half_period;
  logic                   step;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   bp_en;
  logic [ADDR_WIDTH-1:0]  bp_addr;
  logic                   bp_clear;
  logic [ADDR_WIDTH-1:0]  addr_bus;

  logic                   mpu_clk;
  logic                   phi2_rise;
  logic                   phi2_fall;
  logic                   busy;
  logic                   bp_hit;
  logic [31:0]            cycle_count;

  modport master (
    output mode, half_period, step, burst_len, bp_en, bp_addr, bp_clear, addr_bus,
    input  mpu_clk, phi2_rise, phi2_fall, busy, bp_hit, cycle_count
  );

  modport slave (
    input  mode, half_period, step, burst_len, bp_en, bp_addr, bp_clear, addr_bus,
    output mpu_clk, phi2_rise, phi2_fall, busy, bp_hit, cycle_count
  );

endinterface

// File: rtl/mpu_clock_gen.sv
// Programmable 6502 phase-2 clock generator with halt, run, single-step,
// burst and address-breakpoint control. All outputs are registered.
module mpu_clock_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  mpu_clock_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HALT  = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  state_t                 r_state;
  logic [DIV_WIDTH-1:0]   r_phaseCnt;
  logic [DIV_WIDTH-1:0]   r_phaseLen;
  logic [BURST_WIDTH-1:0] r_remaining;
  logic                   r_mpuClk;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;
  logic                   r_bpHit;
  logic [31:0]            r_cycleCount;

  state_t                 w_state;
  logic [DIV_WIDTH-1:0]   w_phaseCnt;
  logic [DIV_WIDTH-1:0]   w_phaseLen;
  logic [BURST_WIDTH-1:0] w_remaining;
  logic                   w_mpuClk;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_busy;
  logic                   w_bpHit;
  logic [31:0]            w_cycleCount;

  logic [DIV_WIDTH-1:0]   w_heff;
  logic [ADDR_WIDTH-1:0]  w_addr;
  logic                   w_phaseDone;
  logic                   w_bpMatch;
  logic                   w_runOk;
  logic                   w_setHit;

  // Each phase length is latched on entry so a mid-phase half_period change never makes a runt.
  assign w_heff      = (bus.half_period == '0) ? DIV_WIDTH'(1) : bus.half_period;
  assign w_phaseDone = (r_phaseCnt == (r_phaseLen - DIV_WIDTH'(1)));
  assign w_addr      = bus.addr_bus;
  assign w_bpMatch   = bus.bp_en && (w_addr == bus.bp_addr);
  assign w_runOk     = (bus.mode == MODE_RUN) && !r_bpHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_phaseCnt   <= '0;
      r_phaseLen   <= DIV_WIDTH'(1);
      r_remaining  <= '0;
      r_mpuClk     <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_busy       <= 1'b0;
      r_bpHit      <= 1'b0;
      r_cycleCount <= '0;
    end else begin
      r_state      <= w_state;
      r_phaseCnt   <= w_phaseCnt;
      r_phaseLen   <= w_phaseLen;
      r_remaining  <= w_remaining;
      r_mpuClk     <= w_mpuClk;
      r_rise       <= w_rise;
      r_fall       <= w_fall;
      r_busy       <= w_busy;
      r_bpHit      <= w_bpHit;
      r_cycleCount <= w_cycleCount;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_phaseCnt   = r_phaseCnt;
    w_phaseLen   = r_phaseLen;
    w_remaining  = r_remaining;
    w_mpuClk     = r_mpuClk;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_busy       = r_busy;
    w_bpHit      = r_bpHit;
    w_cycleCount = r_cycleCount;
    w_setHit     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_mpuClk = 1'b0;
        w_busy   = 1'b0;
        if ((w_runOk) ||
            (bus.mode == MODE_STEP && bus.step) ||
            (bus.mode == MODE_BURST && bus.step && bus.burst_len != '0)) begin
          w_state     = ST_HIGH;
          w_mpuClk    = 1'b1;
          w_rise      = 1'b1;
          w_busy      = 1'b1;
          w_phaseCnt  = '0;
          w_phaseLen  = w_heff;
          w_remaining = (bus.mode == MODE_BURST) ? bus.burst_len - BURST_WIDTH'(1) : '0;
        end
      end

      ST_HIGH: begin
        if (w_phaseDone) begin
          w_state      = ST_LOW;
          w_mpuClk     = 1'b0;
          w_fall       = 1'b1;
          w_phaseCnt   = '0;
          w_phaseLen   = w_heff;
          w_cycleCount = r_cycleCount + 32'd1;
          if (w_bpMatch) begin
            w_setHit    = 1'b1;
            w_remaining = '0;
          end
        end else begin
          w_phaseCnt = r_phaseCnt + DIV_WIDTH'(1);
        end
      end

      ST_LOW: begin
        if (w_phaseDone) begin
          w_phaseCnt = '0;
          w_phaseLen = w_heff;
          if (w_runOk) begin
            w_state  = ST_HIGH;
            w_mpuClk = 1'b1;
            w_rise   = 1'b1;
          end else if (bus.mode == MODE_BURST && r_remaining != '0) begin
            w_state     = ST_HIGH;
            w_mpuClk    = 1'b1;
            w_rise      = 1'b1;
            w_remaining = r_remaining - BURST_WIDTH'(1);
          end else begin
            w_state = ST_IDLE;
            w_busy  = 1'b0;
          end
        end else begin
          w_phaseCnt = r_phaseCnt + DIV_WIDTH'(1);
        end
      end

      default: begin
        w_state  = ST_IDLE;
        w_mpuClk = 1'b0;
        w_busy   = 1'b0;
      end
    endcase

    // A hit on the same edge as bp_clear wins so a breakpoint is never lost.
    if (w_setHit) begin
      w_bpHit = 1'b1;
    end else if (bus.bp_clear) begin
      w_bpHit = 1'b0;
    end
  end

  assign bus.mpu_clk     = r_mpuClk;
  assign bus.phi2_rise   = r_rise;
  assign bus.phi2_fall   = r_fall;
  assign bus.busy        = r_busy;
  assign bus.bp_hit      = r_bpHit;
  assign bus.cycle_count = r_cycleCount;

endmodule

// File: doc/mpu_clock_gen.md
Name: mpu_clock_gen

Overview:
Parametrised 6502 phase-2 clock generator, successor to the fixed clock divider. Produces mpu_clk from the board clock with a runtime-programmable half-period. Supports halt, free-run, single-step and N-cycle burst modes, plus an address breakpoint that stops the MPU clock cleanly. Sits between the debounced front-panel controls and the 6502 clock pin; its pulse outputs drive the bus monitor and debug printer.

Parameters:
DIV_WIDTH, 16, width of half_period.
BURST_WIDTH, 8, width of burst_len and the internal remaining-cycle counter.
ADDR_WIDTH, 16, width of addr_bus and bp_addr.

Ports:
clk  input  1  board clock; single clock domain.
rst  input  1  synchronous reset, active-high.
mode  input  2  0 HALT, 1 RUN, 2 STEP, 3 BURST.
half_period  input  DIV_WIDTH  clk cycles per mpu_clk phase (H); 0 is treated as 1.
step  input  1  one-clk start pulse (from debouncer PB_down).
burst_len  input  BURST_WIDTH  cycles to run per BURST start.
bp_en  input  1  breakpoint enable.
bp_addr  input  ADDR_WIDTH  breakpoint address.
bp_clear  input  1  one-clk pulse; clears bp_hit.
addr_bus  input  ADDR_WIDTH  6502 address bus.
mpu_clk  output  1  phase-2 clock to the MPU.
phi2_rise  output  1  one-clk pulse, first clk of high phase.
phi2_fall  output  1  one-clk pulse, first clk of low phase.
busy  output  1  high whenever state is not IDLE.
bp_hit  output  1  sticky breakpoint flag.
cycle_count  output  32  completed MPU cycles, wraps modulo 2^32.

Behaviour:
- All outputs registered. Reset: state IDLE, mpu_clk 0, phi2_rise 0, phi2_fall 0, busy 0, bp_hit 0, cycle_count 0, phase counter 0, remaining 0. Reset mid-cycle truncates the cycle immediately.
- States: IDLE (mpu_clk 0), HIGH, LOW. Each MPU cycle = HIGH then LOW, each exactly Heff = max(half_period,1) clks. half_period sampled at entry to each phase; changes mid-phase affect only later phases.
- Start from IDLE, evaluated every clk: RUN and !bp_hit -> start; STEP and step -> start, remaining 0; BURST and step and burst_len != 0 -> start, remaining = burst_len-1; BURST with burst_len 0 -> no start. HALT -> stay IDLE.
- On the start edge: state HIGH, mpu_clk 1, phi2_rise 1, busy 1, counter 0.
- HIGH: counter increments; on the edge where counter == Heff-1: state LOW, mpu_clk 0, phi2_fall 1, counter 0, cycle_count +1, addr_bus sampled at this edge. If bp_en and addr_bus == bp_addr: bp_hit set, remaining forced to 0.
- LOW: on the edge where counter == Heff-1, continue to HIGH (phi2_rise 1) iff (mode RUN and !bp_hit) or (mode BURST and remaining != 0, remaining decremented); otherwise IDLE, busy 0.
- Free-run period 2*Heff clks, 50% duty, no idle gap between cycles.
- No runt pulses: mode changes, step pulses or bp_hit never shorten a phase in progress; the current cycle always completes.
- step while busy is ignored, never queued.
- bp_hit remains set until bp_clear or rst. While set, RUN cannot start or continue, but STEP and BURST still start (stepping past a breakpoint). A new hit on the same edge as bp_clear takes precedence: bp_hit stays 1.
- Mode change RUN->STEP mid-cycle: finish cycle, go IDLE. STEP->RUN while IDLE: start next clk.
- cycle_count wraps 0xFFFFFFFF -> 0 without any flag.

Test Plan:
- rst held 3 clks mid-HIGH -> next clk mpu_clk 0, busy 0, bp_hit 0, cycle_count 0.
- RUN, half_period 2 -> mpu_clk pattern 1,1,0,0 repeating; phi2_rise every 4 clks; cycle_count +1 per 4 clks.
- STEP, half_period 3, one step pulse -> mpu_clk high exactly 3 clks, low 3 clks, then IDLE; cycle_count 1; a second step during busy ignored.
- BURST, burst_len 3, half_period 1 -> exactly 3 phi2_rise pulses, mpu_clk 1,0,1,0,1,0, then busy 0; burst_len 0 -> no activity.
- RUN, bp_en 1, bp_addr 0xFFFC, addr_bus 0xFFFC at the third falling edge -> bp_hit 1, clock stops after that low phase, cycle_count 3; bp_clear -> run resumes the next clk.
- RUN, half_period 4, mode to HALT 1 clk into HIGH -> high lasts full 4 clks, low 4 clks, then IDLE; half_period 0 in RUN -> behaves as 1 (period 2).
